regfile_dump_reader: RTL



---
 rtl/regfile_dump_reader_if.sv | 27 ++
 rtl/regfile_dump_reader.sv | 91 +++++++++
 2 files changed

// File: rtl/regfile_dump_reader_if.sv
// Output beat channel of the register-file dump reader: one (address, data) beat per handshake.
interface regfile_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  // A beat transfers on a rising clk edge where out_valid and out_ready are both high.
  // Once out_valid is raised, out_addr/out_data stay stable until that transfer edge;
  // out_ready may toggle freely and is ignored while out_valid is low.
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a wrapping address range through an asynchronous register-file read port and
// streams each captured word out as an (address, data) beat.
module regfile_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    first_addr,
  input  logic [ADDR_W-1:0]    last_addr,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  regfile_dump_reader_if.master dump,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] last_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              hs;

  assign hs = out_valid_q & dump.out_ready;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = READ;
      READ: state_n = HOLD;
      HOLD: if (hs) state_n = (cur == last_q) ? DONE : READ;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cur         <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            cur    <= first_addr;
            last_q <= last_addr;
          end
        end
        // rd_data reflects the array before any write landing on this same edge.
        READ: begin
          out_data_q  <= rd_data;
          out_addr_q  <= cur;
          out_valid_q <= 1'b1;
        end
        HOLD: begin
          if (hs) begin
            out_valid_q <= 1'b0;
            if (cur != last_q) cur <= cur + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // All outputs are decoded from registers only; out_ready never reaches an output.
  assign rd_addr        = (state == READ || state == HOLD) ? cur : '0;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign state_dbg      = state;
  assign dump.out_valid = out_valid_q;
  assign dump.out_addr  = out_addr_q;
  assign dump.out_data  = out_data_q;

endmodule
